// File: rtl/tl_pkg.sv
// TileLink-UL opcode constants and the D-channel response record shared by the SRAM port.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tl_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // Widest source ID the response record can carry; narrower IDs are zero-extended.
    localparam int SRC_MAX_W   = 16;
    localparam int QUEUE_DEPTH = 3;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [1:0]           size;
        logic [SRC_MAX_W-1:0] source;
        logic [31:0]          data;
        logic                 denied;
        logic                 corrupt;
    } resp_t;

    // Circular pointer advance for the 3-entry queue: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] qptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/tl_resp_queue.sv
// 3-entry FIFO of D-channel response records with occupancy count.
// Latency: an entry written at a clock edge is visible at the head in the next cycle.
// Backpressure: holds the head while out_ready is low; the producer reserves space before enqueueing.
module tl_resp_queue
    import tl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enq,
    input  resp_t      enq_rec,
    output logic       out_valid,
    input  logic       out_ready,
    output resp_t      out_rec,
    output logic [1:0] count
);

    resp_t      slots [QUEUE_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic       deq;

    assign out_valid = (count != 2'd0);
    assign deq       = out_valid & out_ready;
    assign out_rec   = slots[rd_ptr];

    // Record storage: payload needs no reset, validity lives in count.
    always_ff @(posedge clock) begin
        if (enq) begin
            slots[wr_ptr] <= enq_rec;
        end
    end

    // Pointer and occupancy update; simultaneous enq and deq leaves count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (enq) wr_ptr <= qptr_next(wr_ptr);
            if (deq) rd_ptr <= qptr_next(rd_ptr);
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tl_sram_port.sv
// Single-beat TileLink-UL slave driving a 1-cycle-latency synchronous SRAM; denies illegal requests.
// Latency: request fire in cycle t gives a response on the D channel in cycle t+2 when the queue is empty.
// Backpressure: a_ready drops when queued plus in-flight responses would exceed the 3-entry queue.
module tl_sram_port
    import tl_pkg::*;
#(
    parameter int ADDR_W      = 26,
    parameter int SOURCE_W    = 7,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           a_valid,
    output logic                           a_ready,
    input  logic [2:0]                     a_opcode,
    input  logic [2:0]                     a_param,
    input  logic [1:0]                     a_size,
    input  logic [SOURCE_W-1:0]            a_source,
    input  logic [ADDR_W-1:0]              a_address,
    input  logic [3:0]                     a_mask,
    input  logic [31:0]                    a_data,
    output logic                           d_valid,
    input  logic                           d_ready,
    output logic [2:0]                     d_opcode,
    output logic [1:0]                     d_param,
    output logic [1:0]                     d_size,
    output logic [SOURCE_W-1:0]            d_source,
    output logic [31:0]                    d_data,
    output logic                           d_denied,
    output logic                           d_corrupt,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr,
    output logic [3:0]                     mem_wmask,
    output logic [31:0]                    mem_wdata,
    input  logic [31:0]                    mem_rdata
);

    localparam int MEM_AW = $clog2(DEPTH_WORDS);
    // One bit wider than the word index so DEPTH_WORDS itself is representable.
    localparam logic [ADDR_W-2:0] DEPTH_LIM = (ADDR_W-1)'(DEPTH_WORDS);

    logic              in_reset;
    logic              fire;
    logic              is_get;
    logic              is_put;
    logic              legal;
    logic [ADDR_W-3:0] word_idx;
    logic [2:0]        occupancy;

    logic                s1_valid;
    logic [SOURCE_W-1:0] s1_source;
    logic [1:0]          s1_size;
    logic                s1_is_get;
    logic                s1_denied;

    resp_t      resp;
    resp_t      q_rec;
    logic [1:0] q_count;
    logic       unused_ok;

    assign word_idx = a_address[ADDR_W-1:2];
    assign is_put   = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
    assign is_get   = (a_opcode == GET);
    assign legal    = (is_put || is_get) && (a_size <= 2'd2) && ({1'b0, word_idx} < DEPTH_LIM);

    // Ready depends only on registered state, never on d_ready or a_valid.
    assign occupancy = {1'b0, q_count} + {2'b00, s1_valid};
    assign a_ready   = !in_reset && (occupancy < 3'd3);
    assign fire      = a_valid & a_ready;

    // SRAM is driven combinationally in the fire cycle; illegal requests never touch it.
    assign mem_en    = fire & legal;
    assign mem_we    = mem_en & is_put;
    assign mem_addr  = word_idx[MEM_AW-1:0];
    assign mem_wmask = mem_we ? a_mask : 4'b0000;
    assign mem_wdata = a_data;

    // Holds a_ready low for the first edge after reset release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) in_reset <= 1'b1;
        else       in_reset <= 1'b0;
    end

    // Stage 1: remember request attributes while the SRAM read completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_source <= '0;
            s1_size   <= 2'd0;
            s1_is_get <= 1'b0;
            s1_denied <= 1'b0;
        end else begin
            s1_valid <= fire;
            if (fire) begin
                s1_source <= a_source;
                s1_size   <= a_size;
                s1_is_get <= is_get;
                s1_denied <= !legal;
            end
        end
    end

    // Build the response; denied reads return zero data and are marked corrupt.
    always_comb begin
        resp         = '0;
        resp.opcode  = s1_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
        resp.size    = s1_size;
        resp.source  = SRC_MAX_W'(s1_source);
        resp.data    = (s1_is_get && !s1_denied) ? mem_rdata : 32'h0;
        resp.denied  = s1_denied;
        resp.corrupt = s1_denied & s1_is_get;
    end

    tl_resp_queue u_queue (
        .clock     (clock),
        .reset     (reset),
        .enq       (s1_valid),
        .enq_rec   (resp),
        .out_valid (d_valid),
        .out_ready (d_ready),
        .out_rec   (q_rec),
        .count     (q_count)
    );

    assign d_opcode  = q_rec.opcode;
    assign d_param   = 2'b00;
    assign d_size    = q_rec.size;
    assign d_source  = q_rec.source[SOURCE_W-1:0];
    assign d_data    = q_rec.data;
    assign d_denied  = q_rec.denied;
    assign d_corrupt = q_rec.corrupt;

    assign unused_ok = ^{a_param, a_address[1:0], q_rec.source};

endmodule

// File: doc/tl_sram_port.md
# tl_sram_port

Single-beat TileLink-UL slave that terminates the A/D channels leaving the fragmenter and drives a 1-cycle-latency synchronous SRAM macro. Accepts Get/PutFullData/PutPartialData beats of at most 4 bytes on a 32-bit bus and returns AccessAck/AccessAckData in request order. Illegal opcodes, oversize requests and out-of-range addresses receive a denied response with no memory access. A 3-entry response queue absorbs D-channel backpressure while keeping full throughput.

## Interface
- Parameters:
- ADDR_W, 26, A-channel byte address width
- SOURCE_W, 7, source ID width
- DEPTH_WORDS, 1024, SRAM depth in 32-bit words; word index = a_address[ADDR_W-1:2]
- Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- a_valid / a_ready  in / out  1 / 1  A-channel handshake
- a_opcode, a_param  in  3, 3  TL opcode; param ignored
- a_size  in  2  log2 bytes
- a_source  in  SOURCE_W  request ID
- a_address  in  ADDR_W  byte address
- a_mask, a_data  in  4, 32  byte lanes, write data
- d_valid / d_ready  out / in  1 / 1  D-channel handshake
- d_opcode, d_param, d_size  out  3, 2, 2  response opcode, 0, echoed size
- d_source  out  SOURCE_W  echoed source
- d_data  out  32  read data
- d_denied, d_corrupt  out  1, 1  error flags
- mem_en, mem_we  out  1, 1  SRAM enable, write enable
- mem_addr  out  log2(DEPTH_WORDS)  word index
- mem_wmask, mem_wdata  out  4, 32  byte write enables, write data
- mem_rdata  in  32  valid the cycle after a read enable

## Operation
- Legal iff opcode in {0 PutFull, 1 PutPartial, 4 Get}, a_size <= 2, word index < DEPTH_WORDS.
- Fire = a_valid & a_ready. On legal fire: mem_en=1 combinationally; mem_we=1 for Puts with mem_wmask=a_mask, mem_wdata=a_data; Get drives mem_we=0, mem_wmask=0.
- Illegal fire: no SRAM access; response d_denied=1; d_corrupt=1 if Get.
- Stage s1 registers {source, size, is_get, denied}; in cycle after fire, response built and enqueued unconditionally (space pre-reserved).
- Response: Get -> d_opcode=1 (AccessAckData), d_data=mem_rdata (0 if denied); Put/illegal non-Get -> d_opcode=0, d_data=0. d_param=0 always.
- a_ready = !in_reset & (queue_count + s1_valid < 3); no combinational path from d_ready or a_valid.
- Queue dequeues on d_valid & d_ready; strict FIFO order.

## Timing
- Fire in cycle t -> response head visible on d_valid at cycle t+2 (queue empty).
- Sustained 1 request/cycle with d_ready held high.
- d_* stable while d_valid & !d_ready.
- Simultaneous enqueue and dequeue on full-minus-one count: count unchanged.
- Queue full (3) plus nothing in flight: a_ready=0 until a dequeue edge.
- Reset (any time, async): s1_valid=0, queue count=0, pointers 0, d_valid=0, a_ready=0, mem_en=0, mem_we=0; in-flight and queued responses discarded; a_ready rises first cycle after reset deasserts (registered in_reset flop).

## Structure
- Shared package tl_pkg: opcode constants (PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1), response record typedef {opcode, size, source, data, denied, corrupt}.
- Sub-module tl_resp_queue: 3-entry FIFO of response records, count output, circular pointers wrapping 2->0.
- Top: legality decode, SRAM drive, s1 register, ready logic.

## Test plan
- PutFull addr 0x10 mask 0xF data 0xDEADBEEF, then Get 0x10 -> mem_we pulse with mem_addr 4; AccessAck then AccessAckData data 0xDEADBEEF, sources echoed.
- PutPartial mask 0x3 data 0x0000CAFE over 0xDEADBEEF, Get -> 0xDEADCAFE.
- Get at word index DEPTH_WORDS, and opcode 2 -> mem_en never asserted; d_denied=1; Get gets d_corrupt=1, d_data=0.
- d_ready=0 with 5 back-to-back Gets -> exactly 3 accepted, a_ready low; release d_ready -> responses in order, remaining 2 accepted.
- d_ready=1, 16 back-to-back Gets -> a_ready never drops, 16 responses on consecutive cycles starting 2 cycles after first fire.
- Assert reset with 2 queued + 1 in flight -> d_valid=0 immediately; after release no stale response, a_ready=1 next cycle.
